// File: rtl/apple_mini_pkg.sv
// Shared ASCII constants and read-FSM encoding for the Apple-1 keyboard/USB path.
package apple_mini_pkg;

    localparam logic [6:0] NUL    = 7'h00;
    localparam logic [6:0] BS     = 7'h08;
    localparam logic [6:0] LF     = 7'h0A;
    localparam logic [6:0] CR     = 7'h0D;
    localparam logic [6:0] DEL    = 7'h7F;
    localparam logic [6:0] RUBOUT = 7'h5F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_RECOVER = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rx_queue.sv
// Circular character buffer with registered head output and synchronous flush.
// Latency: a push into an empty queue shows on head_dat/head_vld one edge later.
// Backpressure: pops only when head_vld && pop; pushes while full are ignored.
module rx_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic                   head_vld,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt, count_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             do_push, do_pop;

    assign count     = wr_ptr - rd_ptr;
    assign do_push   = push && (count != PW'(DEPTH));
    assign do_pop    = head_vld && pop;
    assign wr_nxt    = wr_ptr + PW'(do_push);
    assign rd_nxt    = rd_ptr + PW'(do_pop);
    assign count_nxt = wr_nxt - rd_nxt;

    // The new head may be the entry being written on this very edge.
    always_comb begin
        head_nxt = head_dat;
        if (count_nxt != '0) begin
            if (do_push && (rd_nxt == wr_ptr)) head_nxt = push_dat;
            else                               head_nxt = mem[rd_nxt[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            head_vld <= 1'b0;
            head_dat <= '0;
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            head_vld <= (count_nxt != '0);
            head_dat <= head_nxt;
        end
    end

endmodule

// File: rtl/ft245_rx.sv
// FT245 read-strobe engine, Apple-1 keyboard translation and character queue.
// Latency: RXF# fall to RD# low 3 edges; RD# rise (capture) to rx_valid 2 edges.
// Backpressure: no new read starts while the queue is full; rx_ready pops the head.
module ft245_rx
    import apple_mini_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int RD_CYCLES      = 2,
    parameter int RECOVER_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       fifo_rxf,
    output logic       fifo_rd,
    input  logic [7:0] fifo_data,
    output logic [6:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] drop_count
);
    localparam int CW = 8;
    localparam int QW = $clog2(DEPTH) + 1;

    logic          rxf_meta, rxf_s;
    rd_state_t     state, state_nxt;
    logic [CW-1:0] cyc_cnt, cyc_cnt_nxt;
    logic          rd_done, rec_done, rd_nxt, cap_nxt;
    logic          cap_v, kill, last_cr;
    logic [7:0]    raw;
    logic          raw_msb_unused;
    logic [6:0]    c, xl_dat;
    logic          xl_drop, tr_v;
    logic [6:0]    tr_dat;
    logic [QW-1:0] q_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxf_meta <= 1'b1;
            rxf_s    <= 1'b1;
        end else begin
            rxf_meta <= fifo_rxf;
            rxf_s    <= rxf_meta;
        end
    end

    assign rd_done  = (cyc_cnt == CW'(RD_CYCLES - 1));
    assign rec_done = (cyc_cnt == CW'(RECOVER_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cyc_cnt <= '0;
            fifo_rd <= 1'b1;
            cap_v   <= 1'b0;
            raw     <= '0;
        end else begin
            state   <= state_nxt;
            cyc_cnt <= cyc_cnt_nxt;
            fifo_rd <= rd_nxt;
            cap_v   <= cap_nxt;
            if (cap_nxt) raw <= fifo_data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (!rxf_s && (q_count < QW'(DEPTH))) state_nxt = ST_RD;
            ST_RD:      if (rd_done)  state_nxt = ST_RECOVER;
            ST_RECOVER: if (rec_done) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_nxt      = (state_nxt != ST_RD);
        cap_nxt     = (state == ST_RD) && rd_done;
        cyc_cnt_nxt = (state_nxt != state) ? '0 : cyc_cnt + CW'(1);
    end

    // A flush during a read lets the pin protocol finish but marks its byte dead.
    always_ff @(posedge clk) begin
        if (reset)                  kill <= 1'b0;
        else if (clear)             kill <= (state != ST_IDLE);
        else if (state == ST_IDLE)  kill <= 1'b0;
    end

    assign c              = raw[6:0];
    assign raw_msb_unused = raw[7];

    always_comb begin
        xl_drop = 1'b0;
        xl_dat  = c;
        if (c == NUL) begin
            xl_drop = 1'b1;
        end else if (c == LF) begin
            if (last_cr) xl_drop = 1'b1;
            else         xl_dat  = CR;
        end else if ((c >= 7'h61) && (c <= 7'h7A)) begin
            xl_dat = c - 7'h20;
        end else if ((c == BS) || (c == DEL)) begin
            xl_dat = RUBOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tr_v       <= 1'b0;
            tr_dat     <= '0;
            last_cr    <= 1'b0;
            drop_count <= '0;
        end else begin
            tr_v   <= cap_v && !kill && !clear && !xl_drop;
            tr_dat <= xl_dat;
            if (clear)              last_cr <= 1'b0;
            else if (cap_v && !kill) last_cr <= (c == CR);
            if (cap_v && !kill && !clear && xl_drop) drop_count <= drop_count + 8'd1;
        end
    end

    rx_queue #(
        .DEPTH (DEPTH),
        .WIDTH (7)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .push     (tr_v),
        .push_dat (tr_dat),
        .pop      (rx_ready),
        .head_dat (rx_data),
        .head_vld (rx_valid),
        .count    (q_count)
    );

endmodule

// File: tb/tb_ft245_rx.sv
// Self-checking bench for ft245_rx: FT245 host model, pin monitor and character scoreboard.
module tb_ft245_rx;

    typedef struct {
        logic [7:0] din;
        logic [6:0] exp_dat;
        logic       exp_drop;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, clear, fifo_rxf, fifo_rd, rx_valid, rx_ready;
    logic [7:0] fifo_data, drop_count;
    logic [6:0] rx_data;

    always #5 clk = ~clk;

    ft245_rx dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .fifo_rxf   (fifo_rxf),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .drop_count (drop_count)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] hq[$];
    logic [6:0] exp_q[$];
    vec_t       vecs[16];

    int   cyc = 0, rd_falls = 0, rd_fall_cyc = -1000, rd_rise_cyc = -1000;
    int   rxf_fall_cyc = 0, min_spacing = 1000, low_cnt = 0, last_width = 0;
    int   cons_mode = 0, pop_req = 0, pop_ack = 0, sync_req = 0, sync_ack = 0;
    logic mon_prev_rd = 1'b1, mon_prev_rxf = 1'b1, host_prev_rd = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_falls(input int target, input int limit, input string name);
        for (int i = 0; i < limit && rd_falls < target; i++) step();
        check(name, 32'(rd_falls >= target), 1);
    endtask

    task automatic wait_drain(input int limit, input string name);
        for (int i = 0; i < limit && (hq.size() != 0 || exp_q.size() != 0); i++) step();
        check(name, hq.size() + exp_q.size(), 0);
    endtask

    // FT245 host: RXF# low while bytes are pending, byte popped when RD# rises.
    initial begin
        fifo_rxf  = 1'b1;
        fifo_data = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (!host_prev_rd && fifo_rd && hq.size() != 0) void'(hq.pop_front());
            host_prev_rd = fifo_rd;
            fifo_rxf     = (hq.size() == 0);
            fifo_data    = (hq.size() != 0) ? hq[0] : 8'h00;
        end
    end

    // Pin monitor, consumer and scoreboard, all on the falling edge.
    initial begin
        logic [6:0] e;
        rx_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_prev_rxf && !fifo_rxf) rxf_fall_cyc = cyc;
            mon_prev_rxf = fifo_rxf;
            if (mon_prev_rd && !fifo_rd) begin
                if (cyc - rd_fall_cyc < min_spacing) min_spacing = cyc - rd_fall_cyc;
                rd_fall_cyc = cyc;
                rd_falls++;
            end
            if (!mon_prev_rd && fifo_rd) begin
                last_width  = low_cnt;
                rd_rise_cyc = cyc;
            end
            if (fifo_rd === 1'b0) low_cnt++;
            else                  low_cnt = 0;
            mon_prev_rd = fifo_rd;

            rx_ready = 1'b0;
            if (cons_mode == 1) begin
                rx_ready = 1'b1;
            end else if (sync_ack < sync_req) begin
                if (cyc == rd_rise_cyc + 1) begin
                    rx_ready = 1'b1;
                    sync_ack++;
                end
            end else if (pop_ack < pop_req && rx_valid) begin
                rx_ready = 1'b1;
                pop_ack++;
            end

            if (rx_ready && rx_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %0h expected nothing", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", 32'(rx_data), 32'(e));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int drops_exp;
        vecs = '{
            '{8'h61, 7'h41, 1'b0}, '{8'h0D, 7'h0D, 1'b0}, '{8'h0A, 7'h00, 1'b1},
            '{8'h00, 7'h00, 1'b1}, '{8'h0A, 7'h0D, 1'b0}, '{8'hE2, 7'h42, 1'b0},
            '{8'h7F, 7'h5F, 1'b0}, '{8'h08, 7'h5F, 1'b0}, '{8'h7A, 7'h5A, 1'b0},
            '{8'h7B, 7'h7B, 1'b0}, '{8'h60, 7'h60, 1'b0}, '{8'h8D, 7'h0D, 1'b0},
            '{8'h00, 7'h00, 1'b1}, '{8'h0A, 7'h0D, 1'b0}, '{8'h8D, 7'h0D, 1'b0},
            '{8'h8A, 7'h00, 1'b1}
        };
        reset = 1'b1;
        clear = 1'b0;
        repeat (3) step();
        check("rst_fifo_rd", 32'(fifo_rd), 1);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        reset = 1'b0;
        repeat (3) step();

        // Single byte: latency, pulse width, capture-to-valid
        base = rd_falls;
        hq.push_back(8'h61);
        exp_q.push_back(7'h41);
        wait_falls(base + 1, 50, "single_fall");
        for (int i = 0; i < 10 && fifo_rd == 1'b0; i++) step();
        check("single_rd_latency", rd_fall_cyc - rxf_fall_cyc, 3);
        check("single_valid_e0", 32'(rx_valid), 0);
        step();
        check("single_valid_e1", 32'(rx_valid), 0);
        step();
        check("single_valid_e2", 32'(rx_valid), 1);
        check("single_data", 32'(rx_data), 32'h41);
        check("single_width", last_width, 2);
        repeat (15) step();
        check("single_one_pulse", rd_falls - base, 1);
        pop_req++;
        repeat (3) step();
        check("single_popped", 32'(rx_valid), 0);

        // Filter table streamed through with the consumer always ready
        base = rd_falls;
        drops_exp = 0;
        cons_mode = 1;
        foreach (vecs[i]) begin
            hq.push_back(vecs[i].din);
            if (vecs[i].exp_drop) drops_exp++;
            else                  exp_q.push_back(vecs[i].exp_dat);
        end
        wait_drain(400, "filter_drain");
        repeat (5) step();
        check("filter_drops", 32'(drop_count), drops_exp);
        check("filter_reads", rd_falls - base, 16);
        cons_mode = 0;

        // Back-pressure: four reads fill the queue, one pop admits one more
        repeat (5) step();
        base = rd_falls;
        for (int i = 0; i < 6; i++) begin
            hq.push_back(8'(8'h61 + i));
            exp_q.push_back(7'(7'h41 + i));
        end
        wait_falls(base + 4, 100, "bp_fill");
        repeat (40) step();
        check("bp_stall_reads", rd_falls - base, 4);
        check("bp_rd_high", 32'(fifo_rd), 1);
        check("bp_valid", 32'(rx_valid), 1);
        pop_req++;
        repeat (40) step();
        check("bp_one_more", rd_falls - base, 5);
        check("bp_spacing", 32'(min_spacing >= 6), 1);
        cons_mode = 1;
        wait_drain(200, "bp_drain");
        cons_mode = 0;

        // Push and pop on the same edge at count DEPTH-1
        repeat (10) step();
        base = rd_falls;
        for (int i = 0; i < 3; i++) begin
            hq.push_back(8'(8'h61 + i));
            exp_q.push_back(7'(7'h41 + i));
        end
        wait_falls(base + 3, 60, "pp_fill");
        repeat (10) step();
        sync_req++;
        for (int i = 3; i < 6; i++) begin
            hq.push_back(8'(8'h61 + i));
            exp_q.push_back(7'(7'h41 + i));
        end
        repeat (60) step();
        check("pp_sync_pop", sync_ack, sync_req);
        check("pp_reads", rd_falls - base, 5);
        check("pp_rd_high", 32'(fifo_rd), 1);
        cons_mode = 1;
        wait_drain(200, "pp_drain");
        cons_mode = 0;

        // Clear during the fourth RD pulse
        repeat (10) step();
        base = rd_falls;
        hq.push_back(8'h6B);
        hq.push_back(8'h6C);
        hq.push_back(8'h0D);
        hq.push_back(8'h6D);
        wait_falls(base + 4, 80, "clr_reach");
        check("clr_in_rd", 32'(fifo_rd), 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (20) step();
        check("clr_valid", 32'(rx_valid), 0);
        check("clr_width", last_width, 2);
        check("clr_reads", rd_falls - base, 4);
        check("clr_drops", 32'(drop_count), drops_exp);
        cons_mode = 1;
        hq.push_back(8'h0A);
        exp_q.push_back(7'h0D);
        hq.push_back(8'h71);
        exp_q.push_back(7'h51);
        wait_drain(100, "clr_recover");
        repeat (5) step();
        cons_mode = 0;
        check("clr_after_valid", 32'(rx_valid), 0);

        // Reset in the middle of an RD pulse
        repeat (5) step();
        base = rd_falls;
        hq.push_back(8'h31);
        wait_falls(base + 1, 50, "rstm_reach");
        check("rstm_in_rd", 32'(fifo_rd), 0);
        reset = 1'b1;
        step();
        check("rstm_fifo_rd", 32'(fifo_rd), 1);
        check("rstm_valid", 32'(rx_valid), 0);
        check("rstm_drops", 32'(drop_count), 0);
        reset = 1'b0;
        repeat (20) step();
        check("rstm_lost", 32'(rx_valid), 0);
        check("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ft245_rx.md
# ft245_rx

Receive-side front end between the FT245 USB FIFO read port and `fifo_mux`'s keyboard path. Runs the FT245 read strobe protocol on `clk`, captures each host byte, translates it to the Apple-1 keyboard character set, and queues the result in a small buffer. The buffer presents characters through a valid/ready handshake. `fifo_mux` sees clean 7-bit uppercase keystrokes and never drives RD# itself.

## Interface
- `DEPTH`, 4: buffer entries. Must be a power of two, ≥2.
- `RD_CYCLES`, 2: `clk` cycles RD# is held low. At 12 MHz this is ≥50 ns.
- `RECOVER_CYCLES`, 3: idle cycles after RD# rises before RXF# is re-examined. Must be ≥3 (2-stage synchroniser plus RD#-to-RXF# delay).
- `clk`  in  1  12 MHz system clock.
- `reset`  in  1  Synchronous, active-high reset.
- `clear`  in  1  Synchronous flush of the buffer and translation state.
- `fifo_rxf`  in  1  FT245 RXF#, active low, asynchronous.
- `fifo_rd`  out  1  FT245 RD#, active low, registered.
- `fifo_data`  in  8  FT245 data bus, read direction.
- `rx_data`  out  7  Head-of-buffer character.
- `rx_valid`  out  1  `rx_data` is valid.
- `rx_ready`  in  1  Consumer accepts the head character this cycle.
- `drop_count`  out  8  Count of bytes discarded by the filter. Wraps modulo 256.

## Operation
- `fifo_rxf` passes through a 2-flop synchroniser to produce `rxf_s`. No other input is synchronised.
- Read FSM states: IDLE, RD, RECOVER.
  - IDLE → RD when `rxf_s`==0 and the buffer count < DEPTH. `fifo_rd` goes low on that edge.
  - RD: after RD_CYCLES cycles, `fifo_rd` returns high. On that same edge `fifo_data` is latched into `raw` and `cap_v` is set for one cycle. State → RECOVER.
  - RECOVER: count RECOVER_CYCLES cycles, then → IDLE.
- Translation is applied on the cycle after capture. Let c = `raw[6:0]`; bit 7 is always stripped.
  - c==0x00 → drop.
  - c==0x0A and `last_cr` → drop.
  - c==0x0A otherwise → 0x0D.
  - c in 0x61..0x7A → c−0x20.
  - c==0x08 or c==0x7F → 0x5F (Apple-1 rubout).
  - All other values pass unchanged.
  - `last_cr` ← (c==0x0D). It updates on every captured byte, including dropped bytes.
- Each drop increments `drop_count`. Surviving characters are pushed into the buffer.
- Buffer: circular, DEPTH entries, pointers of log2(DEPTH)+1 bits.
  - A pop happens when `rx_valid` and `rx_ready` are both high.
  - Push and pop in the same cycle leave the count unchanged.
  - `rx_ready` while empty has no effect.
  - Overflow cannot occur, because a read starts only when count < DEPTH and at most one byte is in flight.
- `clear`:
  - Empties the buffer and clears `last_cr`. `drop_count` is unaffected.
  - An RD/RECOVER sequence already in progress completes its pin protocol. A byte captured in that sequence is discarded.
- `reset`: forces IDLE, `fifo_rd`=1, buffer empty, `last_cr`=0, `drop_count`=0, synchroniser=1s. An RD# pulse in progress is cut short and its byte is lost.

## Timing
- Reset values: `fifo_rd`=1, `rx_valid`=0, `rx_data`=0, `drop_count`=0.
- RXF# falling to `fifo_rd` low: 3 edges (2 synchroniser edges plus the FSM edge), with the buffer not full.
- `fifo_rd` low width is exactly RD_CYCLES cycles. Data is sampled on the edge on which RD# rises.
- Minimum spacing between RD# falling edges is RD_CYCLES+RECOVER_CYCLES+1 cycles (6 with defaults).
- Capture to `rx_valid` (empty buffer, byte not dropped): 2 edges. Edge 1 translates; edge 2 writes the buffer and updates `rx_valid`.
- `rx_valid`/`rx_data` are registered from the buffer state. They change only on `clk` edges.
- When full, `fifo_rd` stays high while RXF# is low. The first read after a pop starts on the edge after count drops.

## Structure
- Shared package `apple_mini_pkg` holds:
  - ASCII constants CR, LF, NUL, BS, DEL, RUBOUT.
  - The read FSM state encoding.
- One sub-module, `rx_queue`: synchronous FIFO with push/pop/clear, count, and registered head output, parameterised by DEPTH and width 7.
- Synchroniser, FSM, and translator live in `ft245_rx`.

## Test plan
- Reset mid-read: reset asserted while `fifo_rd`=0 → `fifo_rd`=1 and `rx_valid`=0 on the next edge; `drop_count`=0.
- Single byte: `fifo_rxf` held low with data 0x61; `fifo_rxf` raised after the first RD# rise → exactly one RD# pulse, 2 cycles low. `rx_data`=0x41 with `rx_valid` 2 edges after RD# rises. `rx_ready` pulse → `rx_valid`=0.
- Filter: stream 0x0D, 0x0A, 0x00, 0x0A, 0xE2, 0x7F → buffer yields 0x0D, 0x0D, 0x62→0x42, 0x5F. `drop_count`=2.
- Back-pressure: `rx_ready`=0 with `fifo_rxf` held low → exactly 4 reads, then `fifo_rd` stays high. One pop → exactly one further RD# pulse. RD# falling edges are spaced ≥6 cycles apart.
- Clear: 3 chars buffered, `clear` pulsed during an RD pulse → `rx_valid`=0 afterwards. The in-flight byte does not appear. The RD# pulse still completes with 2 low cycles.
- Simultaneous push and pop at count=DEPTH−1 → count unchanged, order preserved, no lost or duplicated character.
